character_physics: RTL and testbench

CHARACTER_PHYSICS -- requirements
Module: character_physics

---
 rtl/character_physics.sv | 180 ++++++++++++++++++
 tb/tb_character_physics.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/character_physics.sv
// rtl/character_physics.sv - frame-stepped bouncing character physics and game FSM
//
// Purpose: holds the character position/velocity and the IDLE/RUN/PAUSED/DEAD
// game state; applies gravity, platform bounce, ceiling clamp, floor death and
// keyboard-driven horizontal motion with wrap once per frame_tick while running.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   frame_tick           one-cycle pulse per video frame (physics step strobe)
//   start, pause         one-cycle command pulses
//   keycode              current keyboard code (7/79 right, 4/80 left)
//   platform_hit         character bottom overlaps a platform top
//   PosX, PosY           character position
//   VelY                 signed vertical velocity, positive is downward
//   Size                 constant character half-size
//   state                00 IDLE, 01 RUN, 10 PAUSED, 11 DEAD
//   jump_pulse           one cycle per bounce (including the spawn bounce)
//   dead                 high while state is DEAD
module character_physics #(
  parameter int W        = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE     = 4,
  parameter int GRAVITY  = 1,
  parameter int JUMP_VEL = 12,
  parameter int MAX_FALL = 8,
  parameter int X_STEP   = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic [7:0]         keycode,
  input  logic               platform_hit,
  output logic [W-1:0]       PosX,
  output logic [W-1:0]       PosY,
  output logic signed [7:0]  VelY,
  output logic [W-1:0]       Size,
  output logic [1:0]         state,
  output logic               jump_pulse,
  output logic               dead
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DEAD   = 2'b11
  } state_t;

  localparam logic [W-1:0]        X_SPAWN  = W'(X_CENTER);
  localparam logic [W-1:0]        Y_SPAWN  = W'(Y_CENTER);
  localparam logic [W:0]          X_SPAN   = (W+1)'(X_MAX + 1);
  localparam logic [W:0]          X_LAST   = (W+1)'(X_MAX);
  localparam logic [W:0]          X_DELTA  = (W+1)'(X_STEP);
  localparam logic signed [W:0]   Y_LIMIT  = (W+1)'(Y_MAX - SIZE);
  localparam logic signed [7:0]   VEL_JUMP = 8'(-JUMP_VEL);
  localparam logic signed [8:0]   GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]   MAXF9    = 9'(MAX_FALL);

  state_t                state_q, state_d;
  logic [W-1:0]          pos_x_q, pos_x_d;
  logic [W-1:0]          pos_y_q, pos_y_d;
  logic signed [7:0]     vel_y_q, vel_y_d;
  logic                  jump_q, jump_d;

  logic signed [W:0]     y_next;
  logic signed [8:0]     vel_inc;
  logic signed [7:0]     vel_fall;
  logic                  falling;
  logic [W:0]            x_wide;
  logic [W:0]            x_right;
  logic [W:0]            x_left;
  logic [W-1:0]          x_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pos_x_q <= X_SPAWN;
      pos_y_q <= Y_SPAWN;
      vel_y_q <= '0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_y_q <= vel_y_d;
      jump_q  <= jump_d;
    end
  end

  // Datapath candidates for one physics step, all based on the old VelY.
  always_comb begin
    falling  = !vel_y_q[7] && (vel_y_q != 8'sd0);
    y_next   = $signed({1'b0, pos_y_q}) + (W+1)'(vel_y_q);
    vel_inc  = 9'(vel_y_q) + GRAV9;
    vel_fall = (vel_inc > MAXF9) ? MAXF9[7:0] : vel_inc[7:0];

    // Wrap keeps the column inside 0..X_MAX without a modulo.
    x_wide  = {1'b0, pos_x_q};
    x_right = x_wide + X_DELTA;
    if (x_right > X_LAST) begin
      x_right = x_right - X_SPAN;
    end
    if (x_wide < X_DELTA) begin
      x_left = x_wide + X_SPAN - X_DELTA;
    end else begin
      x_left = x_wide - X_DELTA;
    end

    case (keycode)
      8'd7, 8'd79: x_next = x_right[W-1:0];
      8'd4, 8'd80: x_next = x_left[W-1:0];
      default:     x_next = pos_x_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_y_d = vel_y_q;
    jump_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DEAD: begin
        if (start) begin
          state_d = S_RUN;
          pos_x_d = X_SPAWN;
          pos_y_d = Y_SPAWN;
          vel_y_d = VEL_JUMP;
          jump_d  = 1'b1;
        end
      end
      S_PAUSED: begin
        if (pause) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A pause on a tick wins: that frame is skipped entirely.
        if (pause) begin
          state_d = S_PAUSED;
        end else if (frame_tick) begin
          if (falling && (y_next > Y_LIMIT)) begin
            // Falling through the floor freezes the last on-screen position.
            state_d = S_DEAD;
          end else begin
            pos_x_d = x_next;
            if (y_next[W]) begin
              pos_y_d = '0;
              vel_y_d = '0;
            end else begin
              pos_y_d = y_next[W-1:0];
              if (falling && platform_hit) begin
                vel_y_d = VEL_JUMP;
                jump_d  = 1'b1;
              end else begin
                vel_y_d = vel_fall;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PosX       = pos_x_q;
  assign PosY       = pos_y_q;
  assign VelY       = vel_y_q;
  assign Size       = W'(SIZE);
  assign state      = state_q;
  assign jump_pulse = jump_q;
  assign dead       = (state_q == S_DEAD);

endmodule

// File: tb/tb_character_physics.sv
// tb/tb_character_physics.sv - directed vector bench for character_physics
module tb_character_physics;

  logic              Clk;
  logic              Reset;
  logic              frame_tick;
  logic              start;
  logic              pause;
  logic [7:0]        keycode;
  logic              platform_hit;
  logic [9:0]        PosX;
  logic [9:0]        PosY;
  logic signed [7:0] VelY;
  logic [9:0]        Size;
  logic [1:0]        state;
  logic              jump_pulse;
  logic              dead;

  int n_checks = 0;
  int n_fail   = 0;

  character_physics dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .pause        (pause),
    .keycode      (keycode),
    .platform_hit (platform_hit),
    .PosX         (PosX),
    .PosY         (PosY),
    .VelY         (VelY),
    .Size         (Size),
    .state        (state),
    .jump_pulse   (jump_pulse),
    .dead         (dead)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         n;
    logic       st;
    logic       pa;
    logic       tk;
    logic [7:0] key;
    logic       hit;
    int         x;
    int         y;
    int         v;
    logic [1:0] s;
    logic       jp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int x, input int y, input int v,
                           input logic [1:0] s, input logic jp);
    check({nm, ".state"}, int'(state), int'(s));
    check({nm, ".PosX"}, int'(PosX), x);
    check({nm, ".PosY"}, int'(PosY), y);
    check({nm, ".VelY"}, int'(VelY), v);
    check({nm, ".jump"}, int'(jump_pulse), int'(jp));
    check({nm, ".dead"}, int'(dead), int'(s == 2'b11));
  endtask

  // Drive one input pattern for n clock edges, sample 1 ns after the last edge.
  task automatic drive(input int n, input logic st, input logic pa, input logic tk,
                       input logic [7:0] key, input logic hit);
    start        = st;
    pause        = pa;
    frame_tick   = tk;
    keycode      = key;
    platform_hit = hit;
    repeat (n) @(posedge Clk);
    #1;
    start        = 1'b0;
    pause        = 1'b0;
    frame_tick   = 1'b0;
    keycode      = 8'd0;
    platform_hit = 1'b0;
  endtask

  initial begin
    Reset        = 1'b1;
    frame_tick   = 1'b0;
    start        = 1'b0;
    pause        = 1'b0;
    keycode      = 8'd0;
    platform_hit = 1'b0;

    //           n  st pa tk key    hit  x    y    v   state  jp
    tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 320, 240,   0, 2'b00, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd7,  0, 320, 240,   0, 2'b00, 0});
    tbl.push_back('{1, 0, 1, 0, 8'd0,  0, 320, 240,   0, 2'b00, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 320, 240, -12, 2'b01, 1});
    tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 320, 240, -12, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd7,  1, 322, 228, -11, 2'b01, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 322, 228, -11, 2'b01, 0});
    tbl.push_back('{1, 0, 1, 0, 8'd0,  0, 322, 228, -11, 2'b10, 0});
    tbl.push_back('{10,0, 0, 1, 8'd7,  1, 322, 228, -11, 2'b10, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 322, 228, -11, 2'b10, 0});
    tbl.push_back('{1, 0, 1, 0, 8'd0,  0, 322, 228, -11, 2'b01, 0});
    tbl.push_back('{1, 0, 1, 1, 8'd7,  0, 322, 228, -11, 2'b10, 0});
    tbl.push_back('{1, 0, 1, 0, 8'd0,  0, 322, 228, -11, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd4,  0, 320, 217, -10, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd80, 0, 318, 207,  -9, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd79, 0, 320, 198,  -8, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd9,  0, 320, 190,  -7, 2'b01, 0});
    tbl.push_back('{7, 0, 0, 1, 8'd0,  0, 320, 162,   0, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd0,  1, 320, 162,   1, 2'b01, 0});
    tbl.push_back('{3, 0, 0, 1, 8'd0,  0, 320, 168,   4, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd0,  0, 320, 172,   5, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd0,  1, 320, 177, -12, 2'b01, 1});
    tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 320, 177, -12, 2'b01, 0});
    tbl.push_back('{12,0, 0, 1, 8'd0,  0, 320,  99,   0, 2'b01, 0});
    tbl.push_back('{8, 0, 0, 1, 8'd0,  0, 320, 127,   8, 2'b01, 0});
    tbl.push_back('{43,0, 0, 1, 8'd0,  0, 320, 471,   8, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd7,  1, 320, 471,   8, 2'b11, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd7,  0, 320, 471,   8, 2'b11, 0});
    tbl.push_back('{1, 0, 1, 0, 8'd0,  0, 320, 471,   8, 2'b11, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 320, 240, -12, 2'b01, 1});
    tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 320, 240, -12, 2'b01, 0});
    tbl.push_back('{55,0, 0, 1, 8'd0,  0, 320, 470,   8, 2'b01, 0});
    tbl.push_back('{1, 0, 0, 1, 8'd0,  0, 320, 470,   8, 2'b11, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 320, 240, -12, 2'b01, 1});

    repeat (2) @(posedge Clk);
    #1;
    check_all("reset", 320, 240, 0, 2'b00, 1'b0);
    check("size", int'(Size), 4);
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].n, tbl[i].st, tbl[i].pa, tbl[i].tk, tbl[i].key, tbl[i].hit);
      check_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].s, tbl[i].jp);
    end

    // Asynchronous reset in the middle of a run.
    drive(3, 0, 0, 1, 8'd0, 0);
    check_all("prerst", 320, 207, -9, 2'b01, 1'b0);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check_all("rst_run", 320, 240, 0, 2'b00, 1'b0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    drive(3, 0, 0, 1, 8'd7, 1);
    check_all("post_rst", 320, 240, 0, 2'b00, 1'b0);

    // Asynchronous reset while paused.
    drive(1, 1, 0, 0, 8'd0, 0);
    drive(1, 0, 1, 0, 8'd0, 0);
    check_all("paused", 320, 240, -12, 2'b10, 1'b0);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check_all("rst_pause", 320, 240, 0, 2'b00, 1'b0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Long run with platform_hit held: climbs to the ceiling and stays alive
    // while walking left far enough to wrap.
    drive(1, 1, 0, 0, 8'd0, 0);
    check_all("start2", 320, 240, -12, 2'b01, 1'b1);
    drive(12, 0, 0, 1, 8'd4, 1);
    check_all("apex", 296, 162, 0, 2'b01, 1'b0);
    drive(30, 0, 0, 1, 8'd4, 1);
    check_all("climb2", 236, 9, -12, 2'b01, 1'b1);
    drive(1, 0, 0, 1, 8'd4, 1);
    check_all("ceiling", 234, 0, 0, 2'b01, 1'b0);
    drive(1, 0, 0, 1, 8'd4, 1);
    check_all("after_ceil", 232, 0, 1, 2'b01, 1'b0);
    drive(116, 0, 0, 1, 8'd4, 1);
    check_all("at_left", 0, 0, 0, 2'b01, 1'b0);
    drive(1, 0, 0, 1, 8'd4, 1);
    check_all("wrap_left", 638, 0, 1, 2'b01, 1'b0);
    drive(1, 0, 0, 1, 8'd7, 1);
    check_all("wrap_right", 0, 1, -12, 2'b01, 1'b1);
    drive(1, 0, 0, 1, 8'd9, 1);
    check_all("no_move", 0, 0, 0, 2'b01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
